// File: rtl/i2c_master_ctrl_if.sv
// rtl/i2c_master_ctrl_if.sv - host request/response and I2C line-intent bundle for i2c_master_ctrl
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       sda_low;
    logic       scl_low;
    logic       sda_in;
    logic       scl_in;

    modport master (
        input  start, rw, addr, wdata, sda_in, scl_in,
        output busy, done, ack_err, rdata, sda_low, scl_low
    );

    modport slave (
        output start, rw, addr, wdata, sda_in, scl_in,
        input  busy, done, ack_err, rdata, sda_low, scl_low
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master sequencer (START, addr+R/W, data byte, STOP)
// Optional macro I2C_CLK_STRETCH_EN: hold the quarter divider while a slave stretches SCL.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_master_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_WR,
        ST_WACK,
        ST_RD,
        ST_RNACK,
        ST_STOP
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_wdata;
    logic             r_rw;
    logic             r_ack_in;
    logic             r_sda_low;
    logic             r_done;
    logic             r_ack_err;
    logic [7:0]       r_rdata;

    logic             w_hold;
    logic             w_tick;
    logic             w_slot_end;
    logic             w_sample;
    logic             w_accept;
    logic             w_sda_want;
    logic             w_scl_low;

`ifdef I2C_CLK_STRETCH_EN
    // SCL is always released by the master in Q2/Q3, so a low level there is the slave.
    assign w_hold = r_q[1] && (r_state != ST_IDLE) && !bus.scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = bus.scl_in;
    assign w_hold       = 1'b0;
`endif

    assign w_tick     = (r_div == DIV_LAST) && !w_hold;
    assign w_slot_end = w_tick && (r_q == 2'd3);
    assign w_sample   = (r_q == 2'd3) && (r_div == '0) && !w_hold;
    // The done cycle is already IDLE; a start coinciding with it is dropped.
    assign w_accept   = (r_state == ST_IDLE) && bus.start && !r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_sda_want  = 1'b0;
        w_scl_low   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_sda_want = r_q[1];
                if (w_slot_end) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                w_scl_low  = !r_q[1];
                w_sda_want = !r_shift[7];
                if (w_slot_end && (r_bit == 3'd7)) w_state_nxt = ST_AACK;
            end
            ST_AACK: begin
                w_scl_low = !r_q[1];
                if (w_slot_end) w_state_nxt = r_ack_in ? ST_STOP : (r_rw ? ST_RD : ST_WR);
            end
            ST_WR: begin
                w_scl_low  = !r_q[1];
                w_sda_want = !r_shift[7];
                if (w_slot_end && (r_bit == 3'd7)) w_state_nxt = ST_WACK;
            end
            ST_WACK: begin
                w_scl_low = !r_q[1];
                if (w_slot_end) w_state_nxt = ST_STOP;
            end
            ST_RD: begin
                w_scl_low = !r_q[1];
                if (w_slot_end && (r_bit == 3'd7)) w_state_nxt = ST_RNACK;
            end
            ST_RNACK: begin
                w_scl_low = !r_q[1];
                if (w_slot_end) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                w_scl_low  = !r_q[1];
                w_sda_want = (r_q != 2'd3);
                if (w_slot_end) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_wdata   <= 8'h00;
            r_rw      <= 1'b0;
            r_ack_in  <= 1'b0;
            r_sda_low <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            r_done    <= 1'b0;
            // SDA follows one clk behind SCL so data never moves on the falling edge itself.
            r_sda_low <= w_sda_want;
            if (w_accept) begin
                r_rw      <= bus.rw;
                r_shift   <= {bus.addr, bus.rw};
                r_wdata   <= bus.wdata;
                r_ack_err <= 1'b0;
                r_div     <= '0;
                r_q       <= 2'd0;
                r_bit     <= 3'd0;
            end else if (r_state != ST_IDLE) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_q   <= r_q + 2'd1;
                end else if (!w_hold) begin
                    r_div <= r_div + CNT_W'(1);
                end
                if (w_sample) begin
                    r_ack_in <= bus.sda_in;
                    if (r_state == ST_RD) r_shift <= {r_shift[6:0], bus.sda_in};
                end
                if (w_slot_end) begin
                    if ((r_state == ST_ADDR) || (r_state == ST_WR) || (r_state == ST_RD))
                        r_bit <= r_bit + 3'd1;
                    else
                        r_bit <= 3'd0;
                    case (r_state)
                        ST_ADDR, ST_WR: r_shift <= {r_shift[6:0], 1'b0};
                        ST_AACK: begin
                            if (r_ack_in) r_ack_err <= 1'b1;
                            else          r_shift   <= r_wdata;
                        end
                        ST_WACK: begin
                            if (r_ack_in) r_ack_err <= 1'b1;
                        end
                        ST_STOP: begin
                            r_done <= 1'b1;
                            if (r_rw && !r_ack_err) r_rdata <= r_shift;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.ack_err = r_ack_err;
    assign bus.rdata   = r_rdata;
    assign bus.sda_low = r_sda_low;
    assign bus.scl_low = w_scl_low;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed bench for i2c_master_ctrl with an open-drain resolver and byte-level slave
module tb_i2c_master_ctrl;

    logic clk;
    logic rst_n;
    logic s_sda_low;
    logic s_scl_low;

    i2c_master_ctrl_if bus();

    i2c_master_ctrl #(.CLK_DIV(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.sda_in = ~(bus.sda_low | s_sda_low);
    assign bus.scl_in = ~(bus.scl_low | s_scl_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_asserts = 0;
    int         n_fails   = 0;
    logic [7:0] rx_bytes [0:3];
    logic [7:0] sl_tx = 8'h3C;
    logic       sl_mack;
    logic       busy0, ack0, done_ack, done_busy, stretch_bad;
    logic [7:0] done_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte-level slave: ACKs address 7'h50 and write data, returns sl_tx on reads.
    initial begin : slave
        logic p_sda, p_scl, c_sda, c_scl;
        int   sl_k, sl_byte;
        bit   sl_active, sl_addr_ok, sl_rd;
        logic [7:0] sl_rx;
        s_sda_low = 1'b0;
        p_sda = 1'b1; p_scl = 1'b1;
        sl_k = 0; sl_byte = 0; sl_active = 0; sl_addr_ok = 0; sl_rd = 0; sl_rx = 8'h00;
        sl_mack = 1'b0;
        forever begin
            @(negedge clk);
            c_sda = bus.sda_in;
            c_scl = bus.scl_in;
            if (p_scl && c_scl && p_sda && !c_sda) begin
                sl_active = 1; sl_k = 0; sl_byte = 0; sl_rx = 8'h00; s_sda_low = 1'b0;
            end else if (p_scl && c_scl && !p_sda && c_sda) begin
                sl_active = 0; s_sda_low = 1'b0;
            end else if (sl_active && !p_scl && c_scl) begin
                if (sl_k < 8) begin
                    sl_rx = {sl_rx[6:0], c_sda};
                end else if (sl_byte == 1) begin
                    sl_mack = c_sda;
                end
                sl_k++;
                if (sl_k == 8) begin
                    if (sl_byte < 4) rx_bytes[sl_byte] = sl_rx;
                    if (sl_byte == 0) begin
                        sl_addr_ok = (sl_rx[7:1] == 7'h50);
                        sl_rd      = sl_rx[0];
                    end
                end
                if (sl_k == 9) begin
                    sl_k = 0;
                    sl_byte++;
                end
            end else if (sl_active && p_scl && !c_scl) begin
                s_sda_low = 1'b0;
                if (sl_k == 8 && sl_addr_ok && (sl_byte == 0 || !sl_rd))
                    s_sda_low = 1'b1;
                else if (sl_k < 8 && sl_byte == 1 && sl_rd && sl_addr_ok)
                    s_sda_low = ~sl_tx[7 - sl_k];
            end
            p_sda = c_sda;
            p_scl = c_scl;
        end
    end

    task automatic wait_done(input int stretch_at, input int extra_at, input logic [7:0] ex_wdata,
                             output int lat, output int nd);
        bit got;
        got = 0; lat = 0; nd = 0; stretch_bad = 1'b0;
        while (!got && lat < 2000) begin
            @(negedge clk);
            if (lat == 0) begin
                bus.start = 1'b0;
                busy0 = bus.busy;
                ack0  = bus.ack_err;
            end
            if (extra_at >= 0 && lat == extra_at) begin
                bus.wdata = ex_wdata;
                bus.start = 1'b1;
            end
            if (extra_at >= 0 && lat == extra_at + 1) bus.start = 1'b0;
            if (stretch_at >= 0 && lat == stretch_at) s_scl_low = 1'b1;
            if (stretch_at >= 0 && lat == stretch_at + 21) s_scl_low = 1'b0;
            if (stretch_at >= 0 && lat > stretch_at && lat <= stretch_at + 21 && bus.sda_in !== 1'b0)
                stretch_bad = 1'b1;
            if (bus.done) begin
                got = 1; nd++;
                done_ack = bus.ack_err; done_busy = bus.busy; done_rdata = bus.rdata;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_low_with_done", 32'(done_busy), 32'd0);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_with_done_ignored", 32'(bus.busy), 32'd0);
        repeat (3) begin
            if (bus.done) nd++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                       input int stretch_at, input int extra_at, input logic [7:0] ex_wdata,
                       output int lat, output int nd);
        @(negedge clk);
        bus.rw = rw; bus.addr = addr; bus.wdata = wdata; bus.start = 1'b1;
        @(posedge clk);
        wait_done(stretch_at, extra_at, ex_wdata, lat, nd);
    endtask

    initial begin : main
        int lat, nd, ndr;
        rst_n = 1'b0; s_scl_low = 1'b0;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 7'h00; bus.wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_low", 32'(bus.sda_low), 32'd0);
        chk("rst_scl_low", 32'(bus.scl_low), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ack_err", 32'(bus.ack_err), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'h00);
        rst_n = 1'b1;

        txn(1'b0, 7'h50, 8'hA5, -1, -1, 8'h00, lat, nd);
        chk("wr_busy_after_accept", 32'(busy0), 32'd1);
        chk("wr_latency", 32'(lat), 32'd320);
        chk("wr_done_count", 32'(nd), 32'd1);
        chk("wr_addr_byte", 32'(rx_bytes[0]), 32'hA0);
        chk("wr_data_byte", 32'(rx_bytes[1]), 32'hA5);
        chk("wr_ack_err", 32'(done_ack), 32'd0);

        txn(1'b1, 7'h50, 8'h00, -1, -1, 8'h00, lat, nd);
        chk("rd_latency", 32'(lat), 32'd320);
        chk("rd_addr_byte", 32'(rx_bytes[0]), 32'hA1);
        chk("rd_rdata", 32'(done_rdata), 32'h3C);
        chk("rd_master_nack", 32'(sl_mack), 32'd1);
        chk("rd_ack_err", 32'(done_ack), 32'd0);

        txn(1'b0, 7'h21, 8'h55, -1, -1, 8'h00, lat, nd);
        chk("nack_latency", 32'(lat), 32'd176);
        chk("nack_ack_err", 32'(done_ack), 32'd1);
        chk("nack_ack_err_held", 32'(bus.ack_err), 32'd1);
        chk("nack_rdata_kept", 32'(bus.rdata), 32'h3C);

        txn(1'b0, 7'h50, 8'h11, -1, 49, 8'h77, lat, nd);
        chk("busy_start_ack_err_cleared", 32'(ack0), 32'd0);
        chk("busy_start_latency", 32'(lat), 32'd320);
        chk("busy_start_one_done", 32'(nd), 32'd1);
        chk("busy_start_old_data", 32'(rx_bytes[1]), 32'h11);
        chk("busy_start_ack_err", 32'(done_ack), 32'd0);

        txn(1'b0, 7'h50, 8'h77, -1, -1, 8'h00, lat, nd);
        chk("next_txn_new_data", 32'(rx_bytes[1]), 32'h77);

        @(negedge clk);
        bus.rw = 1'b0; bus.addr = 7'h50; bus.wdata = 8'hA5; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        ndr = 0;
        repeat (215) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) ndr++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_sda_low", 32'(bus.sda_low), 32'd0);
        chk("midrst_scl_low", 32'(bus.scl_low), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        if (bus.done) ndr++;
        chk("midrst_no_done", 32'(ndr), 32'd0);
        rst_n = 1'b1;
        bus.wdata = 8'h5A; bus.start = 1'b1;
        @(posedge clk);
        wait_done(-1, -1, 8'h00, lat, nd);
        chk("postrst_accept", 32'(busy0), 32'd1);
        chk("postrst_latency", 32'(lat), 32'd320);
        chk("postrst_data_byte", 32'(rx_bytes[1]), 32'h5A);

`ifdef I2C_CLK_STRETCH_EN
        txn(1'b0, 7'h50, 8'hA5, 151, -1, 8'h00, lat, nd);
        chk("stretch_latency", 32'(lat), 32'd340);
        chk("stretch_sda_stable", 32'(stretch_bad), 32'd0);
        chk("stretch_data_byte", 32'(rx_bytes[1]), 32'hA5);
        chk("stretch_ack_err", 32'(done_ack), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
